// File: rtl/uart_slave.sv
// uart_slave: memory-mapped UART peripheral for bus slave 2.
// Provides CTRL/STATUS/BAUD/TXDATA/RXDATA registers and an 8N1 transmitter.
// The 8N1 receiver is compiled in only when the UART_RX_EN macro is defined;
// without it the receiver logic is absent and its register fields read zero.

`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 32
`endif
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif
`ifndef ZERO_WORD
`define ZERO_WORD {`DATA_BUS_WIDTH{1'b0}}
`endif

module uart_slave #(
  parameter int BAUD_DIV_RST = 434,
  parameter int DIV_W        = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [`ADDR_BUS_WIDTH-1:0] addr_i,
  input  logic [`DATA_BUS_WIDTH-1:0] data_i,
  output logic [`DATA_BUS_WIDTH-1:0] data_o,
  input  logic                       we_i,
  input  logic                       rd_i,
  output logic                       tx_o,
  input  logic                       rx_i
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_BAUD   = 3'd2;
  localparam logic [2:0] OFF_TXDATA = 3'd3;
  localparam logic [2:0] OFF_RXDATA = 3'd4;

`ifdef UART_RX_EN
  localparam logic [1:0] CTRL_MASK = 2'b11;
`else
  localparam logic [1:0] CTRL_MASK = 2'b01;
`endif

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  logic [2:0]       offset;
  logic             wr_ctrl, wr_status, wr_baud, wr_txdata;
  logic [DIV_W-1:0] div_eff;

  logic [1:0]       ctrl_q, ctrl_d;
  logic [DIV_W-1:0] baud_q, baud_d;

  tx_state_e        tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [DIV_W-1:0] tx_div_q, tx_div_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_q, tx_d;
  logic             tx_busy;

  logic             sts_rx_valid, sts_rx_overrun, sts_rx_frame_err;
  logic [7:0]       sts_rx_data;

  logic             unused_bits;

  assign offset    = addr_i[4:2];
  assign wr_ctrl   = we_i && (offset == OFF_CTRL);
  assign wr_status = we_i && (offset == OFF_STATUS);
  assign wr_baud   = we_i && (offset == OFF_BAUD);
  assign wr_txdata = we_i && (offset == OFF_TXDATA);
  assign div_eff   = (baud_q < DIV_W'(2)) ? DIV_W'(2) : baud_q;
  assign tx_busy   = (tx_state_q != TX_IDLE);
  assign tx_o      = tx_q;

  // Register-file next state: CTRL and BAUD take whole writes, CTRL masked to implemented bits
  always_comb begin
    ctrl_d = ctrl_q;
    baud_d = baud_q;
    if (wr_ctrl) ctrl_d = data_i[1:0] & CTRL_MASK;
    if (wr_baud) baud_d = data_i[DIV_W-1:0];
  end

  // Register-file state
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= 2'b00;
      baud_q <= DIV_W'(BAUD_DIV_RST);
    end else begin
      ctrl_q <= ctrl_d;
      baud_q <= baud_d;
    end
  end

  // Transmitter next state: each bit period lasts the divider latched at frame start
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (wr_txdata && ctrl_q[0]) begin
          tx_state_d = TX_START;
          tx_div_d   = div_eff;
          tx_shift_d = data_i[7:0];
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == tx_div_q - DIV_W'(1)) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_d       = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + DIV_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == tx_div_q - DIV_W'(1)) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + DIV_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == tx_div_q - DIV_W'(1)) begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
          tx_d       = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + DIV_W'(1);
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  // Transmitter state; reset abandons any frame and returns the line to idle high
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= DIV_W'(2);
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

`ifdef UART_RX_EN
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;

  rx_state_e        rx_state_q, rx_state_d;
  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [DIV_W-1:0] rx_div_q, rx_div_d;
  logic [DIV_W-1:0] rx_half;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_overrun_q, rx_overrun_d;
  logic             rx_frame_err_q, rx_frame_err_d;
  logic             rd_clear;

  assign rx_half  = {1'b0, rx_div_q[DIV_W-1:1]};
  assign rd_clear = rd_i && (offset == OFF_RXDATA);

  // Receiver next state; a host read of RXDATA wins over a byte completing in the same cycle
  always_comb begin
    rx_state_d     = rx_state_q;
    rx_cnt_d       = rx_cnt_q;
    rx_div_d       = rx_div_q;
    rx_bit_d       = rx_bit_q;
    rx_shift_d     = rx_shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = rx_valid_q;
    rx_overrun_d   = rx_overrun_q;
    rx_frame_err_d = rx_frame_err_q;
    if (wr_status) begin
      rx_overrun_d   = 1'b0;
      rx_frame_err_d = 1'b0;
    end
    if (rd_clear) rx_valid_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (ctrl_q[1] && rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
          rx_div_d   = div_eff;
        end
      end
      RX_START: begin
        if (rx_cnt_q == rx_half - DIV_W'(1)) begin
          rx_cnt_d = '0;
          if (rx_s2_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_bit_d   = 3'd0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + DIV_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == rx_div_q - DIV_W'(1)) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + DIV_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == rx_div_q - DIV_W'(1)) begin
          rx_cnt_d = '0;
          if (rx_s2_q) begin
            rx_state_d = RX_IDLE;
            rx_data_d  = rx_shift_q;
            if (!rd_clear) begin
              if (rx_valid_q) rx_overrun_d = 1'b1;
              rx_valid_d = 1'b1;
            end
          end else begin
            rx_state_d     = RX_BREAK;
            rx_frame_err_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + DIV_W'(1);
        end
      end
      RX_BREAK: begin
        if (rx_s2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (!ctrl_q[1]) rx_state_d = RX_IDLE;
  end

  // Receiver state plus the two-flop synchroniser and edge-detect history for rx_i
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q        <= 1'b1;
      rx_s2_q        <= 1'b1;
      rx_prev_q      <= 1'b1;
      rx_state_q     <= RX_IDLE;
      rx_cnt_q       <= '0;
      rx_div_q       <= DIV_W'(2);
      rx_bit_q       <= 3'd0;
      rx_shift_q     <= 8'h00;
      rx_data_q      <= 8'h00;
      rx_valid_q     <= 1'b0;
      rx_overrun_q   <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      rx_s1_q        <= rx_i;
      rx_s2_q        <= rx_s1_q;
      rx_prev_q      <= rx_s2_q;
      rx_state_q     <= rx_state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_div_q       <= rx_div_d;
      rx_bit_q       <= rx_bit_d;
      rx_shift_q     <= rx_shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_overrun_q   <= rx_overrun_d;
      rx_frame_err_q <= rx_frame_err_d;
    end
  end

  assign sts_rx_valid     = rx_valid_q;
  assign sts_rx_overrun   = rx_overrun_q;
  assign sts_rx_frame_err = rx_frame_err_q;
  assign sts_rx_data      = rx_data_q;
  assign unused_bits      = ^{addr_i, data_i};
`else
  assign sts_rx_valid     = 1'b0;
  assign sts_rx_overrun   = 1'b0;
  assign sts_rx_frame_err = 1'b0;
  assign sts_rx_data      = 8'h00;
  assign unused_bits      = ^{addr_i, data_i, rd_i, rx_i};
`endif

  // Combinational read mux; reads have no dependency on rd_i
  always_comb begin
    data_o = `ZERO_WORD;
    case (offset)
      OFF_CTRL:   data_o[1:0]       = ctrl_q;
      OFF_STATUS: data_o[3:0]       = {sts_rx_frame_err, sts_rx_overrun, sts_rx_valid, tx_busy};
      OFF_BAUD:   data_o[DIV_W-1:0] = baud_q;
      OFF_RXDATA: data_o[7:0]       = sts_rx_data;
      default:    data_o            = `ZERO_WORD;
    endcase
  end

endmodule

// File: tb/tb_uart_slave.sv
// Self-checking bench for uart_slave. Receiver scenarios run when UART_RX_EN is defined;
// otherwise the bench checks that the receiver fields read zero.
module tb_uart_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] data_i = 32'd0;
  logic [31:0] data_o;
  logic        we_i = 1'b0;
  logic        rd_i = 1'b0;
  logic        tx_o;
  logic        rx_i = 1'b1;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;
  logic       exp_tx_q[$];
  logic [7:0] exp_rx_q[$];

  always #5 clk = ~clk;

  uart_slave dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
    .we_i(we_i), .rd_i(rd_i), .tx_o(tx_o), .rx_i(rx_i)
  );

  // Serial-line monitor: pops one expected tx_o level per cycle, else the line must idle high
  always @(negedge clk) begin
    logic e;
    if (mon_en) begin
      total++;
      if (exp_tx_q.size() > 0) begin
        e = exp_tx_q.pop_front();
        if (tx_o !== e) begin
          bad++;
          $display("[TB] FAIL tx_bit t=%0t: tx_o=%b expected %b", $time, tx_o, e);
        end
      end else if (tx_o !== 1'b1) begin
        bad++;
        $display("[TB] FAIL tx_idle t=%0t: tx_o=%b expected 1", $time, tx_o);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic bus_write(input logic [2:0] off, input logic [31:0] d);
    @(posedge clk); #1;
    addr_i = {27'd0, off, 2'b00};
    data_i = d;
    we_i   = 1'b1;
    @(posedge clk); #1;
    we_i   = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] off, input logic rd, output logic [31:0] d);
    @(posedge clk); #1;
    addr_i = {27'd0, off, 2'b00};
    rd_i   = rd;
    #1 d = data_o;
    @(posedge clk); #1;
    rd_i   = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] b, input int div);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < div; j++) exp_tx_q.push_back(bits[k]);
  endtask

  task automatic tx_write_frame(input logic [7:0] b, input int div);
    bus_write(3'd3, {24'd0, b});
    push_frame(b, div);
  endtask

  task automatic count_busy(output int n);
    addr_i = {27'd0, 3'd1, 2'b00};
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (data_o[0] === 1'b1) n++;
      else break;
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int div, input bit expect_ok);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    if (expect_ok) exp_rx_q.push_back(b);
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      rx_i = bits[k];
      repeat (div) @(posedge clk);
      #1;
    end
    rx_i = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    total++;
    if (tx_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_tx: tx_o=%b expected 1", tx_o); end
    bus_read(3'd2, 1'b0, d);
    total++;
    if (d !== 32'd434) begin bad++; $display("[TB] FAIL reset_baud: got %0d expected 434", d); end
    bus_read(3'd0, 1'b0, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("[TB] FAIL reset_ctrl: got %h expected 0", d); end
    bus_read(3'd1, 1'b0, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("[TB] FAIL reset_status: got %h expected 0", d); end
    bus_read(3'd4, 1'b0, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("[TB] FAIL reset_rxdata: got %h expected 0", d); end
    bus_read(3'd5, 1'b0, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("[TB] FAIL unmapped_read: got %h expected 0", d); end
  endtask

  task automatic test_tx();
    int n;
    logic [31:0] d;
    bus_write(3'd2, 32'd4);
    bus_write(3'd0, 32'd1);
    bus_read(3'd3, 1'b0, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("[TB] FAIL txdata_read: got %h expected 0", d); end
    tx_write_frame(8'hA5, 4);
    count_busy(n);
    total++;
    if (n !== 40) begin bad++; $display("[TB] FAIL tx_busy_len: got %0d expected 40", n); end
    total++;
    if (exp_tx_q.size() !== 0) begin bad++; $display("[TB] FAIL tx_drain: %0d left expected 0", exp_tx_q.size()); end
  endtask

  task automatic test_tx_drop();
    int n;
    logic [31:0] d;
    tx_write_frame(8'h12, 4);
    bus_write(3'd3, 32'h34);
    count_busy(n);
    total++;
    if (n !== 38) begin bad++; $display("[TB] FAIL drop_busy_len: got %0d expected 38", n); end
    bus_write(3'd0, 32'd0);
    bus_write(3'd3, 32'h77);
    bus_read(3'd1, 1'b0, d);
    total++;
    if (d[0] !== 1'b0) begin bad++; $display("[TB] FAIL txen0_busy: got %b expected 0", d[0]); end
    repeat (10) @(posedge clk);
  endtask

  task automatic test_baud_min();
    int n;
    logic [31:0] d;
    bus_write(3'd0, 32'd1);
    bus_write(3'd2, 32'd0);
    bus_read(3'd2, 1'b0, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("[TB] FAIL baud0_read: got %0d expected 0", d); end
    tx_write_frame(8'h5A, 2);
    count_busy(n);
    total++;
    if (n !== 20) begin bad++; $display("[TB] FAIL baud0_busy_len: got %0d expected 20", n); end
  endtask

  task automatic test_back_to_back();
    int n;
    bus_write(3'd2, 32'd4);
    tx_write_frame(8'hC3, 4);
    bus_write(3'd2, 32'd3);
    bus_write(3'd0, 32'd0);
    count_busy(n);
    total++;
    if (n !== 36) begin bad++; $display("[TB] FAIL midframe_cfg_busy: got %0d expected 36", n); end
    bus_write(3'd0, 32'd1);
    tx_write_frame(8'h3C, 3);
    count_busy(n);
    total++;
    if (n !== 30) begin bad++; $display("[TB] FAIL newbaud_busy: got %0d expected 30", n); end
    tx_write_frame(8'h81, 3);
    count_busy(n);
    total++;
    if (n !== 30) begin bad++; $display("[TB] FAIL b2b_busy: got %0d expected 30", n); end
    total++;
    if (exp_tx_q.size() !== 0) begin bad++; $display("[TB] FAIL b2b_drain: %0d left expected 0", exp_tx_q.size()); end
  endtask

`ifdef UART_RX_EN
  task automatic test_rx();
    logic [31:0] d;
    logic [7:0]  e;
    bus_write(3'd2, 32'd8);
    bus_write(3'd0, 32'd2);
    send_rx(8'h3C, 1'b1, 8, 1'b1);
    bus_read(3'd1, 1'b0, d);
    total++;
    if (d[1] !== 1'b1) begin bad++; $display("[TB] FAIL rx_valid_set: got %b expected 1", d[1]); end
    e = exp_rx_q.pop_front();
    bus_read(3'd4, 1'b1, d);
    total++;
    if (d !== {24'd0, e}) begin bad++; $display("[TB] FAIL rx_data: got %h expected %h", d, e); end
    bus_read(3'd1, 1'b0, d);
    total++;
    if (d[1] !== 1'b0) begin bad++; $display("[TB] FAIL rx_valid_clear: got %b expected 0", d[1]); end
  endtask

  task automatic test_rx_errors();
    logic [31:0] d;
    logic [7:0]  e;
    send_rx(8'h11, 1'b1, 8, 1'b1);
    send_rx(8'h22, 1'b1, 8, 1'b1);
    bus_read(3'd1, 1'b0, d);
    total++;
    if (d[3:1] !== 3'b011) begin bad++; $display("[TB] FAIL overrun_status: got %b expected 011", d[3:1]); end
    e = exp_rx_q[$];
    exp_rx_q.delete();
    bus_read(3'd4, 1'b0, d);
    total++;
    if (d !== {24'd0, e}) begin bad++; $display("[TB] FAIL overrun_data: got %h expected %h", d, e); end
    send_rx(8'h55, 1'b0, 8, 1'b0);
    bus_read(3'd1, 1'b0, d);
    total++;
    if (d[3:1] !== 3'b111) begin bad++; $display("[TB] FAIL frame_err_status: got %b expected 111", d[3:1]); end
    bus_read(3'd4, 1'b0, d);
    total++;
    if (d !== {24'd0, e}) begin bad++; $display("[TB] FAIL frame_err_keep: got %h expected %h", d, e); end
    bus_write(3'd1, 32'd0);
    bus_read(3'd1, 1'b0, d);
    total++;
    if (d[3:1] !== 3'b001) begin bad++; $display("[TB] FAIL status_clear: got %b expected 001", d[3:1]); end
    bus_read(3'd4, 1'b1, d);
    @(posedge clk); #1 rx_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx_i = 1'b1;
    repeat (20) @(posedge clk);
    bus_read(3'd1, 1'b0, d);
    total++;
    if (d[3:1] !== 3'b000) begin bad++; $display("[TB] FAIL glitch_ignored: got %b expected 000", d[3:1]); end
    send_rx(8'hA7, 1'b1, 8, 1'b1);
    e = exp_rx_q.pop_front();
    bus_read(3'd4, 1'b0, d);
    total++;
    if (d !== {24'd0, e}) begin bad++; $display("[TB] FAIL post_glitch_data: got %h expected %h", d, e); end
    bus_write(3'd0, 32'd0);
  endtask
`else
  task automatic test_no_rx();
    logic [31:0] d;
    bus_write(3'd0, 32'd3);
    bus_read(3'd0, 1'b0, d);
    total++;
    if (d !== 32'd1) begin bad++; $display("[TB] FAIL norx_ctrl: got %h expected 1", d); end
    send_rx(8'h3C, 1'b1, 4, 1'b0);
    bus_read(3'd4, 1'b0, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("[TB] FAIL norx_rxdata: got %h expected 0", d); end
    bus_read(3'd1, 1'b0, d);
    total++;
    if (d[3:1] !== 3'b000) begin bad++; $display("[TB] FAIL norx_status: got %b expected 000", d[3:1]); end
    bus_write(3'd0, 32'd0);
  endtask
`endif

  task automatic test_reset_mid_tx();
    logic [31:0] d;
    bus_write(3'd0, 32'd1);
    bus_write(3'd2, 32'd4);
    tx_write_frame(8'h00, 4);
    repeat (10) @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_tx_q.delete();
    total++;
    if (tx_o !== 1'b1) begin bad++; $display("[TB] FAIL midreset_tx: tx_o=%b expected 1", tx_o); end
    bus_read(3'd1, 1'b0, d);
    total++;
    if (d[0] !== 1'b0) begin bad++; $display("[TB] FAIL midreset_busy: got %b expected 0", d[0]); end
    bus_read(3'd2, 1'b0, d);
    total++;
    if (d !== 32'd434) begin bad++; $display("[TB] FAIL midreset_baud: got %0d expected 434", d); end
    mon_en = 1'b1;
    repeat (8) @(posedge clk);
  endtask

  initial begin
    test_reset();
    mon_en = 1'b1;
    test_tx();
    test_tx_drop();
    test_baud_min();
    test_back_to_back();
`ifdef UART_RX_EN
    test_rx();
    test_rx_errors();
`else
    test_no_rx();
`endif
    test_reset_mid_tx();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
